// File: rtl/fifo_uart_tx_if.sv
// FIFO read port plus serial-side status, bundled between the byte FIFO and
// the UART transmitter. master = transmitter side, slave = FIFO/pin side.
interface fifo_uart_tx_if;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd_en;
  logic       tx_enable;
  logic       tx;
  logic       busy;
  logic       frame_done;

  modport master (
    input  fifo_empty, fifo_data, tx_enable,
    output fifo_rd_en, tx, busy, frame_done
  );

  modport slave (
    output fifo_empty, fifo_data, tx_enable,
    input  fifo_rd_en, tx, busy, frame_done
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the byte FIFO and serializes each as a UART frame:
// start, 8 data bits LSB-first, optional even parity, 1 or 2 stop bits.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           rst,
  fifo_uart_tx_if.master bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_POP    = 3'd1;
  localparam logic [2:0] S_LATCH  = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
  localparam logic [2:0] S_PARITY = 3'd5;
  localparam logic [2:0] S_STOP   = 3'd6;

  localparam logic [15:0] RELOAD        = 16'(CLKS_PER_BIT - 1);
  localparam logic        LAST_STOP_IDX = 1'(STOP_BITS - 1);

  logic [2:0]  r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit_idx;
  logic        r_stop_idx;
  logic [7:0]  r_shift;
  logic        r_parity;
  logic        r_tx;

  logic w_bit_end;
  logic w_last_stop;

  assign w_bit_end   = (r_cnt == 16'd0);
  assign w_last_stop = (r_stop_idx == LAST_STOP_IDX);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 16'd0;
      r_bit_idx  <= 3'd0;
      r_stop_idx <= 1'b0;
      r_shift    <= 8'd0;
      r_parity   <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (bus.tx_enable && !bus.fifo_empty) begin
            r_state <= S_POP;
          end
        end

        S_POP: begin
          r_state <= S_LATCH;
        end

        // FIFO data is valid the cycle after the pop; capture it and drop tx.
        S_LATCH: begin
          r_shift   <= bus.fifo_data;
          r_parity  <= ^bus.fifo_data;
          r_tx      <= 1'b0;
          r_cnt     <= RELOAD;
          r_bit_idx <= 3'd0;
          r_state   <= S_START;
        end

        S_START: begin
          if (w_bit_end) begin
            r_cnt     <= RELOAD;
            r_bit_idx <= 3'd0;
            r_tx      <= r_shift[0];
            r_state   <= S_DATA;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_cnt <= RELOAD;
            if (r_bit_idx == 3'd7) begin
              if (PARITY_EN != 0) begin
                r_tx    <= r_parity;
                r_state <= S_PARITY;
              end else begin
                r_tx       <= 1'b1;
                r_stop_idx <= 1'b0;
                r_state    <= S_STOP;
              end
            end else begin
              // Drive the next bit directly so tx stays a pure register.
              r_bit_idx <= r_bit_idx + 3'd1;
              r_shift   <= {1'b0, r_shift[7:1]};
              r_tx      <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end

        S_PARITY: begin
          if (w_bit_end) begin
            r_cnt      <= RELOAD;
            r_tx       <= 1'b1;
            r_stop_idx <= 1'b0;
            r_state    <= S_STOP;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end

        S_STOP: begin
          r_tx <= 1'b1;
          if (w_bit_end) begin
            if (w_last_stop) begin
              r_state <= S_IDLE;
            end else begin
              r_cnt      <= RELOAD;
              r_stop_idx <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  // Status outputs are pure decodes of registered state.
  assign bus.tx         = r_tx;
  assign bus.fifo_rd_en = (r_state == S_POP);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.frame_done = (r_state == S_STOP) && w_bit_end && w_last_stop;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Two transmitter instances (8N1 and 8E2, 4 clocks per bit) fed by queue-based
// FIFO models; every frame is compared bit-by-bit against an ideal UART frame.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic clk;
  logic rst;

  fifo_uart_tx_if bus_a ();
  fifo_uart_tx_if bus_b ();

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.master)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // FIFO models: registered empty flag (pre-pop size), data valid after pop.
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  int pushed_a = 0, pushed_b = 0;
  int pops_a = 0, pops_b = 0;
  int rd_empty_a = 0, rd_empty_b = 0;

  always @(posedge clk) begin
    bus_a.fifo_empty <= (q_a.size() == 0);
    if (bus_a.fifo_rd_en) begin
      pops_a++;
      if (q_a.size() == 0) rd_empty_a++;
      else bus_a.fifo_data <= q_a.pop_front();
    end
  end

  always @(posedge clk) begin
    bus_b.fifo_empty <= (q_b.size() == 0);
    if (bus_b.fifo_rd_en) begin
      pops_b++;
      if (q_b.size() == 0) rd_empty_b++;
      else bus_b.fifo_data <= q_b.pop_front();
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic g_tx(input int inst);
    return (inst == 0) ? bus_a.tx : bus_b.tx;
  endfunction
  function automatic logic g_rd(input int inst);
    return (inst == 0) ? bus_a.fifo_rd_en : bus_b.fifo_rd_en;
  endfunction
  function automatic logic g_busy(input int inst);
    return (inst == 0) ? bus_a.busy : bus_b.busy;
  endfunction
  function automatic logic g_done(input int inst);
    return (inst == 0) ? bus_a.frame_done : bus_b.frame_done;
  endfunction

  task automatic push(input int inst, input logic [7:0] b);
    if (inst == 0) begin q_a.push_back(b); pushed_a++; end
    else begin q_b.push_back(b); pushed_b++; end
  endtask

  // Leaves the caller at the negedge of the pop cycle.
  task automatic wait_pop(input int inst);
    bit found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (g_rd(inst) === 1'b1) found = 1;
    end
    chk("pop_timeout", 32'(found), 32'd1);
  endtask

  // Entered at the negedge of the pop cycle. drop_at / abort_at are bit-cycle
  // indices (from the tx fall) at which tx_enable is cleared / reset is applied.
  task automatic check_frame(input int inst, input logic [7:0] b, input int par,
                             input int nstop, input int drop_at, input int abort_at);
    logic bits[$];
    int   len;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (par != 0) bits.push_back(($countones(b) % 2) != 0);
    for (int i = 0; i < nstop; i++) bits.push_back(1'b1);
    len = bits.size() * CPB;

    @(negedge clk);
    chk("latch_rd_low", 32'(g_rd(inst)), 32'd0);
    chk("latch_tx_high", 32'(g_tx(inst)), 32'd1);
    chk("latch_busy", 32'(g_busy(inst)), 32'd1);

    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      chk("frame_tx", 32'(g_tx(inst)), 32'(bits[k / CPB]));
      chk("frame_done", 32'(g_done(inst)), (k == len - 1) ? 32'd1 : 32'd0);
      chk("frame_busy", 32'(g_busy(inst)), 32'd1);
      chk("frame_rd_low", 32'(g_rd(inst)), 32'd0);
      if (k == drop_at) bus_a.tx_enable = 1'b0;
      if (k == abort_at) begin
        rst = 1'b0;
        @(negedge clk);
        chk("abort_tx", 32'(g_tx(inst)), 32'd1);
        chk("abort_busy", 32'(g_busy(inst)), 32'd0);
        chk("abort_done", 32'(g_done(inst)), 32'd0);
        $display("[TB] frame %s byte %02h aborted by reset", (inst == 0) ? "A" : "B", b);
        return;
      end
    end

    @(negedge clk);
    chk("idle_busy", 32'(g_busy(inst)), 32'd0);
    chk("idle_done", 32'(g_done(inst)), 32'd0);
    chk("idle_tx", 32'(g_tx(inst)), 32'd1);
    $display("[TB] frame %s byte %02h checked", (inst == 0) ? "A" : "B", b);
  endtask

  initial begin
    logic [7:0] rb[3];

    // Reset held with a non-empty FIFO and enable set.
    rst = 1'b0;
    bus_a.tx_enable = 1'b1;
    bus_b.tx_enable = 1'b0;
    push(0, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_tx", 32'(bus_a.tx), 32'd1);
      chk("rst_rd", 32'(bus_a.fifo_rd_en), 32'd0);
      chk("rst_busy", 32'(bus_a.busy), 32'd0);
      chk("rst_done", 32'(bus_a.frame_done), 32'd0);
      chk("rst_tx_b", 32'(bus_b.tx), 32'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("first_pop", 32'(bus_a.fifo_rd_en), 32'd1);
    check_frame(0, 8'hA5, 0, 1, -1, -1);

    // Back-to-back bytes: pop must follow the single IDLE cycle immediately.
    push(0, 8'h00); push(0, 8'hFF); push(0, 8'h55);
    wait_pop(0);
    check_frame(0, 8'h00, 0, 1, -1, -1);
    @(negedge clk);
    chk("b2b_pop1", 32'(bus_a.fifo_rd_en), 32'd1);
    check_frame(0, 8'hFF, 0, 1, -1, -1);
    @(negedge clk);
    chk("b2b_pop2", 32'(bus_a.fifo_rd_en), 32'd1);
    check_frame(0, 8'h55, 0, 1, -1, -1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("no_extra_pop", 32'(bus_a.fifo_rd_en), 32'd0);
    end

    // Even parity with two stop bits, then random back-to-back bytes.
    push(1, 8'h07);
    bus_b.tx_enable = 1'b1;
    wait_pop(1);
    check_frame(1, 8'h07, 1, 2, -1, -1);
    for (int i = 0; i < 3; i++) begin
      rb[i] = 8'($urandom);
      push(1, rb[i]);
    end
    wait_pop(1);
    for (int i = 0; i < 3; i++) begin
      if (i != 0) begin
        @(negedge clk);
        chk("b2b_pop_b", 32'(bus_b.fifo_rd_en), 32'd1);
      end
      check_frame(1, rb[i], 1, 2, -1, -1);
    end
    bus_b.tx_enable = 1'b0;

    // Enable dropped during data bit 3 with a second byte queued.
    rb[0] = 8'($urandom);
    rb[1] = 8'($urandom);
    push(0, rb[0]); push(0, rb[1]);
    wait_pop(0);
    check_frame(0, rb[0], 0, 1, 4 * CPB + 1, -1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("gated_no_pop", 32'(bus_a.fifo_rd_en), 32'd0);
      chk("gated_idle", 32'(bus_a.busy), 32'd0);
    end
    bus_a.tx_enable = 1'b1;
    @(negedge clk);
    chk("reenable_pop", 32'(bus_a.fifo_rd_en), 32'd1);
    check_frame(0, rb[1], 0, 1, -1, -1);

    // Reset during data bit 5, then a clean 0x3C frame.
    rb[2] = 8'($urandom);
    push(0, rb[2]);
    wait_pop(0);
    check_frame(0, rb[2], 0, 1, -1, 6 * CPB + 1);
    push(0, 8'h3C);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_hold_done", 32'(bus_a.frame_done), 32'd0);
      chk("rst_hold_rd", 32'(bus_a.fifo_rd_en), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_pop", 32'(bus_a.fifo_rd_en), 32'd1);
    check_frame(0, 8'h3C, 0, 1, -1, -1);

    repeat (4) @(negedge clk);
    chk("pops_a", 32'(pops_a), 32'(pushed_a));
    chk("pops_b", 32'(pops_b), 32'(pushed_b));
    chk("q_a_drained", 32'(q_a.size()), 32'd0);
    chk("q_b_drained", 32'(q_b.size()), 32'd0);
    chk("rd_empty_a", 32'(rd_empty_a), 32'd0);
    chk("rd_empty_b", 32'(rd_empty_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
